// File: rtl/acq_sequencer.sv
// ---------------------------------------------------------------------------
// acq_sequencer
//
// Frame-acquisition controller sitting between the PS control GPIO and the
// G11620 sensor / AD9826 ADC acquisition path. A rising edge on start_in
// launches a run. The run first waits for the AD9826 configuration and then
// executes frame_num_in frames. Each frame is a sensor readout followed by an
// ADC capture, and consecutive frames are separated by gap_in idle cycles.
// The pldata RAM bank alternates on every completed frame. At the end of the
// run a completion interrupt is raised, or a watchdog error if any wait state
// stalls for longer than TIMEOUT cycles.
//
// Ports
//   clk             acquisition clock (5 MHz adcclk domain)
//   rst             asynchronous, active-high reset
//   start_in        PS start level; acted on at its rising edge
//   abort_in        level; returns the sequencer to IDLE
//   frame_num_in    frames per run, latched at start
//   gap_in          idle cycles between frames, latched at start
//   cfg_done_in     AD9826 configuration complete (level)
//   sensor_done_in  G11620 readout done (1-cycle pulse)
//   adc_done_in     AD9826 frame captured (1-cycle pulse)
//   intr_clr_in     PS clears intr_o / err_o
//   sensor_start_o  1-cycle pulse to G11620 start
//   adc_start_o     1-cycle pulse to AD9826 start
//   ram_bank_o      pldata RAM bank for the current frame
//   frame_cnt_o     frames completed in this run
//   busy_o          run in progress
//   done_o          1-cycle pulse at run completion
//   intr_o          sticky interrupt (done or error)
//   err_o           sticky watchdog error
// ---------------------------------------------------------------------------
module acq_sequencer #(
    parameter int unsigned TIMEOUT_W = 20,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic [7:0]  frame_num_in,
    input  logic [15:0] gap_in,
    input  logic        cfg_done_in,
    input  logic        sensor_done_in,
    input  logic        adc_done_in,
    input  logic        intr_clr_in,
    output logic        sensor_start_o,
    output logic        adc_start_o,
    output logic        ram_bank_o,
    output logic [7:0]  frame_cnt_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        intr_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_CFG = 3'd1;
    localparam logic [2:0] S_SENSOR   = 3'd2;
    localparam logic [2:0] S_ADC      = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 start_r;
    logic [7:0]           frame_num_q;
    logic [15:0]          gap_q;
    logic [15:0]          gap_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;

    logic                 start_edge;
    logic                 start_accept;
    logic                 wd_expired;
    logic                 in_wait;
    logic                 frame_accept;
    logic                 intr_set;
    logic [7:0]           frame_cnt_inc;

    assign start_edge    = start_in & ~start_r;
    assign start_accept  = (state == S_IDLE) && start_edge && (frame_num_in != 8'd0);
    assign wd_expired    = (wd_cnt == WD_LAST);
    assign in_wait       = (state == S_WAIT_CFG) || (state == S_SENSOR) || (state == S_ADC);
    assign frame_cnt_inc = frame_cnt_o + 8'd1;
    // A captured frame only counts if the same cycle is not aborting the run.
    assign frame_accept  = (state == S_ADC) && adc_done_in && !abort_in;
    assign intr_set      = ((state == S_FINISH) || (state == S_ERROR)) && !abort_in;

    // done_o is decoded from the FINISH state so it is exactly one cycle wide
    // and coincides with busy_o falling.
    assign done_o = (state == S_FINISH);

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if ((state != S_IDLE) && abort_in) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_accept) state_nxt = S_WAIT_CFG;
                end
                S_WAIT_CFG: begin
                    if (cfg_done_in)     state_nxt = S_SENSOR;
                    else if (wd_expired) state_nxt = S_ERROR;
                end
                S_SENSOR: begin
                    if (sensor_done_in)  state_nxt = S_ADC;
                    else if (wd_expired) state_nxt = S_ERROR;
                end
                S_ADC: begin
                    if (adc_done_in)
                        state_nxt = (frame_cnt_inc == frame_num_q) ? S_FINISH : S_GAP;
                    else if (wd_expired)
                        state_nxt = S_ERROR;
                end
                S_GAP: begin
                    if (gap_cnt == 16'd0) state_nxt = S_SENSOR;
                end
                S_FINISH: state_nxt = S_IDLE;
                S_ERROR:  state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            start_r        <= 1'b0;
            frame_num_q    <= 8'd0;
            gap_q          <= 16'd0;
            gap_cnt        <= 16'd0;
            wd_cnt         <= '0;
            sensor_start_o <= 1'b0;
            adc_start_o    <= 1'b0;
            ram_bank_o     <= 1'b0;
            frame_cnt_o    <= 8'd0;
            busy_o         <= 1'b0;
            intr_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            start_r <= start_in;
            state   <= state_nxt;

            // Start pulses fire on the transition into the state they launch.
            sensor_start_o <= (state_nxt == S_SENSOR) && (state != S_SENSOR);
            adc_start_o    <= (state_nxt == S_ADC) && (state != S_ADC);

            // busy_o drops on entry to FINISH/ERROR, not on leaving them.
            busy_o <= (state_nxt == S_WAIT_CFG) || (state_nxt == S_SENSOR) ||
                      (state_nxt == S_ADC)      || (state_nxt == S_GAP);

            // Watchdog restarts on every state change; it only runs while
            // waiting on an external handshake.
            if (state_nxt != state)
                wd_cnt <= '0;
            else if (in_wait)
                wd_cnt <= wd_cnt + 1'b1;

            if ((state == S_ADC) && (state_nxt == S_GAP))
                gap_cnt <= gap_q;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt - 16'd1;

            if (start_accept) begin
                frame_num_q <= frame_num_in;
                gap_q       <= gap_in;
                frame_cnt_o <= 8'd0;
                ram_bank_o  <= 1'b0;
            end else if (frame_accept) begin
                frame_cnt_o <= frame_cnt_inc;
                ram_bank_o  <= ~ram_bank_o;
            end

            // Setting beats clearing when both happen in one cycle.
            if (intr_set)
                intr_o <= 1'b1;
            else if (start_accept || intr_clr_in)
                intr_o <= 1'b0;

            if ((state == S_ERROR) && !abort_in)
                err_o <= 1'b1;
            else if (start_accept || intr_clr_in)
                err_o <= 1'b0;
        end
    end

endmodule
